dpll_tx_gen: RTL and testbench
==============================

DPLL_TX_GEN -- requirements
Module: dpll_tx_gen

Interface
REQ-001 SHALL have parameter BIT_DIV, default 200000: nominal bit period in clocks (500 bit/s at 100 MHz).
REQ-002 SHALL have parameter STEP, default 2000: phase-jump size in clocks; BIT_DIV-STEP >= 2 and BIT_DIV+STEP < 2^20.
REQ-003 SHALL have parameter PRE_LEN, default 8: preamble length in bits, >= 1.
REQ-004 SHALL have port CLK_100MHz, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high.
REQ-006 SHALL have port start, input, 1 bit: request transmission; level-sensitive.
REQ-007 SHALL have port mode, input, 1 bit: 0 = word data, 1 = PRBS7 data.
REQ-008 SHALL have port data_in, input, 16 bits: word to load.
REQ-009 SHALL have port load, input, 1 bit: write data_in into the holding register.
REQ-010 SHALL have port phase_adj, input, 2 bits: 0 = nominal, 1 = lengthen bit by STEP, 2 = shorten bit by STEP, 3 = treated as 0.
REQ-011 SHALL have port signal, output, 1 bit: serial NRZ line toward the DPLL receiver.
REQ-012 SHALL have port bit_strobe, output, 1 bit: one-cycle pulse on the first clock of every transmitted bit.
REQ-013 SHALL have port ready, output, 1 bit: holding register empty.
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse on return to IDLE.

Function
REQ-016 SHALL implement states IDLE, PREAMBLE and DATA.
REQ-017 IDLE SHALL drive signal=0 and hold the bit counter at 0.
REQ-018 IDLE SHALL move to PREAMBLE when start=1 and either (mode=0 and ready=0) or mode=1.
REQ-019 In mode 0 with ready=1, start SHALL be ignored.
REQ-020 On the cycle after the IDLE->PREAMBLE transition, signal SHALL be 1 and bit_strobe SHALL be 1.
REQ-021 PREAMBLE SHALL send PRE_LEN bits alternating 1,0,1,... starting with 1, then enter DATA.
REQ-022 DATA SHALL send 16 bits per word, MSB first; the source is the shift register in mode 0 and successive PRBS7 outputs in mode 1.
REQ-023 The PRBS7 generator SHALL use x^7+x^6+1 with seed 7'h7F at reset, output its MSB, and advance once per PRBS bit.
REQ-024 At each word start in mode 0, the holding register SHALL transfer to the shift register and ready SHALL rise on the next cycle.
REQ-025 At each word end, the block SHALL continue with the next word if (mode=0 and holding full) or (mode=1 and start=1); otherwise it SHALL enter IDLE with done=1 for one cycle and signal=0.
REQ-026 mode SHALL be sampled only at word boundaries and at IDLE exit.
REQ-027 The bit counter SHALL be 20 bits, count 0..P-1, and assert bit_strobe when at 0 in a non-IDLE state.
REQ-028 P SHALL be latched at each bit start: BIT_DIV, BIT_DIV+STEP (phase_adj=1) or BIT_DIV-STEP (phase_adj=2).
REQ-029 phase_adj SHALL affect only the one bit whose start it is sampled at.
REQ-030 signal SHALL change only on bit_strobe cycles and be registered (glitch-free).
REQ-031 load && ready SHALL capture data_in and drive ready=0 on the next cycle; load with ready=0 SHALL be ignored.
REQ-032 When load coincides with a holding-to-shift transfer, load SHALL be ignored, because ready is 0 that cycle.
REQ-033 Deasserting start mid-word SHALL NOT truncate the word.

Reset
REQ-034 reset=1 SHALL immediately set state=IDLE, signal=0, bit_strobe=0, busy=0, done=0, ready=1, counter=0, holding/shift=0, PRBS=7'h7F, regardless of current operation.
REQ-035 After reset is released, operation SHALL resume on the first rising edge with start=1.

Verification (BIT_DIV=10, STEP=2, PRE_LEN=4)
REQ-036 Bench SHALL cover: load 16'hA5C3, start=1 one cycle, mode=0 -> preamble 1010, then data bits 1010010111000011, each 10 clocks, then done pulse, signal=0, busy=0; total 200 clocks.
REQ-037 Bench SHALL cover: phase_adj=1 held on the 3rd bit start -> that bit lasts 12 clocks; phase_adj=2 -> that bit lasts 8 clocks; all other bits last 10 clocks.
REQ-038 Bench SHALL cover: mode=1, start held high -> after preamble, the first 7 data bits are 1111111, then the sequence repeats every 127 bits with no gap at word boundaries.
REQ-039 Bench SHALL cover: load during a word with ready=1 -> ready=0, the next word sends back-to-back with no idle bit; a second load while ready=0 -> ignored.
REQ-040 Bench SHALL cover: start with mode=0 and ready=1 -> stays IDLE, busy=0.
REQ-041 Bench SHALL cover: reset asserted mid-DATA -> same-cycle signal=0, busy=0, ready=1; the next start restarts from preamble.

Source files
------------

// File: rtl/dpll_tx_gen.sv
// Test-pattern transmitter for a DPLL receiver: preamble plus 16-bit NRZ words
// from a host holding register or a PRBS7 source, with per-bit phase jumps.
module dpll_tx_gen #(
  parameter int BIT_DIV = 200000,
  parameter int STEP    = 2000,
  parameter int PRE_LEN = 8
) (
  input  logic        CLK_100MHz,
  input  logic        reset,
  input  logic        start,
  input  logic        mode,
  input  logic [15:0] data_in,
  input  logic        load,
  input  logic [1:0]  phase_adj,
  output logic        signal,
  output logic        bit_strobe,
  output logic        ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2
  } state_t;

  localparam logic [19:0] P_NOM     = 20'(BIT_DIV);
  localparam logic [19:0] P_LONG    = 20'(BIT_DIV + STEP);
  localparam logic [19:0] P_SHORT   = 20'(BIT_DIV - STEP);
  localparam logic [15:0] PRE_LAST  = 16'(PRE_LEN - 1);
  localparam logic [15:0] DATA_LAST = 16'd15;

  function automatic logic [19:0] period_sel(input logic [1:0] adj);
    logic [19:0] p;
    case (adj)
      2'd1:    p = P_LONG;
      2'd2:    p = P_SHORT;
      default: p = P_NOM;
    endcase
    return p;
  endfunction

  // x^7 + x^6 + 1 Fibonacci LFSR, output taken from the MSB
  function automatic logic [6:0] prbs_next(input logic [6:0] s);
    return {s[5:0], s[6] ^ s[5]};
  endfunction

  state_t      state_r;
  logic [19:0] cnt_r;
  logic [19:0] p_r;
  logic [15:0] idx_r;
  logic        mode_r;
  logic [15:0] hold_r;
  logic [15:0] shift_r;
  logic [6:0]  prbs_r;
  logic        signal_r;
  logic        strobe_r;
  logic        ready_r;
  logic        busy_r;
  logic        done_r;

  logic        bit_end_s;
  logic        go_s;
  logic        word_next_s;
  logic        more_bits_s;
  logic        start_mode_s;

  assign bit_end_s   = (state_r != IDLE) && (cnt_r == p_r - 20'd1);
  assign go_s        = start && (mode || !ready_r);
  assign word_next_s = mode ? start : !ready_r;

  // Word-start source: the mode latched at IDLE exit after the preamble,
  // otherwise the live mode input sampled at the word boundary
  always_comb begin
    start_mode_s = mode;
    more_bits_s  = 1'b0;
    if (state_r == PREAMBLE) begin
      start_mode_s = mode_r;
      more_bits_s  = (idx_r != PRE_LAST);
    end else begin
      start_mode_s = mode;
      more_bits_s  = (idx_r != DATA_LAST);
    end
  end

  // Sequencer, bit timing, data sources and host handshake
  always_ff @(posedge CLK_100MHz or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      cnt_r    <= 20'd0;
      p_r      <= P_NOM;
      idx_r    <= 16'd0;
      mode_r   <= 1'b0;
      hold_r   <= 16'd0;
      shift_r  <= 16'd0;
      prbs_r   <= 7'h7F;
      signal_r <= 1'b0;
      strobe_r <= 1'b0;
      ready_r  <= 1'b1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      strobe_r <= 1'b0;
      done_r   <= 1'b0;
      // A transfer only happens while the holding register is full, so it
      // never collides with an accepted load
      if (load && ready_r) begin
        hold_r  <= data_in;
        ready_r <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          cnt_r    <= 20'd0;
          signal_r <= 1'b0;
          busy_r   <= 1'b0;
          if (go_s) begin
            state_r  <= PREAMBLE;
            busy_r   <= 1'b1;
            mode_r   <= mode;
            idx_r    <= 16'd0;
            signal_r <= 1'b1;
            strobe_r <= 1'b1;
            p_r      <= period_sel(phase_adj);
          end
        end
        PREAMBLE, DATA: begin
          if (!bit_end_s) begin
            cnt_r <= cnt_r + 20'd1;
          end else begin
            cnt_r <= 20'd0;
            if (more_bits_s) begin
              idx_r    <= idx_r + 16'd1;
              strobe_r <= 1'b1;
              p_r      <= period_sel(phase_adj);
              if (state_r == PREAMBLE) begin
                signal_r <= ~signal_r;
              end else if (mode_r) begin
                signal_r <= prbs_r[6];
                prbs_r   <= prbs_next(prbs_r);
              end else begin
                signal_r <= shift_r[15];
                shift_r  <= {shift_r[14:0], 1'b0};
              end
            end else if ((state_r == PREAMBLE) || word_next_s) begin
              state_r  <= DATA;
              idx_r    <= 16'd0;
              strobe_r <= 1'b1;
              p_r      <= period_sel(phase_adj);
              mode_r   <= start_mode_s;
              if (start_mode_s) begin
                signal_r <= prbs_r[6];
                prbs_r   <= prbs_next(prbs_r);
              end else begin
                signal_r <= hold_r[15];
                shift_r  <= {hold_r[14:0], 1'b0};
                ready_r  <= 1'b1;
              end
            end else begin
              state_r  <= IDLE;
              busy_r   <= 1'b0;
              done_r   <= 1'b1;
              signal_r <= 1'b0;
            end
          end
        end
        default: begin
          state_r  <= IDLE;
          cnt_r    <= 20'd0;
          signal_r <= 1'b0;
          busy_r   <= 1'b0;
        end
      endcase
    end
  end

  assign signal     = signal_r;
  assign bit_strobe = strobe_r;
  assign ready      = ready_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_dpll_tx_gen.sv
// Directed bench for dpll_tx_gen (BIT_DIV=10, STEP=2, PRE_LEN=4); all
// driving and sampling happens on the falling clock edge.
module tb_dpll_tx_gen;

  logic        clk;
  logic        reset;
  logic        start;
  logic        mode;
  logic [15:0] data_in;
  logic        load;
  logic [1:0]  phase_adj;
  logic        signal;
  logic        bit_strobe;
  logic        ready;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  bit bits_q[$];
  int lens_q[$];
  int total_cyc;
  bit got_done;

  dpll_tx_gen #(.BIT_DIV(10), .STEP(2), .PRE_LEN(4)) dut (
    .CLK_100MHz(clk),
    .reset(reset),
    .start(start),
    .mode(mode),
    .data_in(data_in),
    .load(load),
    .phase_adj(phase_adj),
    .signal(signal),
    .bit_strobe(bit_strobe),
    .ready(ready),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected line value of frame bit i: preamble 1010 then word MSB first
  function automatic bit exp_frame_bit(input logic [15:0] w, input int i);
    if (i < 4) return (i % 2 == 0);
    return w[19 - i];
  endfunction

  task automatic apply_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic load_word(input logic [15:0] w);
    data_in = w;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
  endtask

  task automatic pulse_start();
    mode  = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Records bit values and lengths until done or budget expiry
  task automatic capture(input int budget, input int adj_bit, input logic [1:0] adj_val,
                         input int stop_after);
    int  last;
    bit  have_last;
    bits_q.delete();
    lens_q.delete();
    got_done  = 1'b0;
    total_cyc = 0;
    last      = 0;
    have_last = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (c > 0) @(negedge clk);
      if (done) begin
        if (have_last) lens_q.push_back(c - last);
        total_cyc = c;
        got_done  = 1'b1;
        break;
      end
      if (bit_strobe) begin
        if (have_last) lens_q.push_back(c - last);
        last      = c;
        have_last = 1'b1;
        bits_q.push_back(signal);
        if (bits_q.size() == adj_bit) phase_adj = adj_val;
        if (bits_q.size() == adj_bit + 1) phase_adj = 2'd0;
        if (bits_q.size() == stop_after) start = 1'b0;
      end
    end
  endtask

  task automatic wait_strobes(input int n, input int budget, output bit ok);
    int seen;
    seen = 0;
    ok   = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (c > 0) @(negedge clk);
      if (bit_strobe) seen++;
      if (seen == n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({signal, bit_strobe, busy, done, ready} !== 5'b00001) begin
      failures++;
      $display("FAIL reset_state: got %b expected 00001 (signal,strobe,busy,done,ready)",
               {signal, bit_strobe, busy, done, ready});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_word();
    int bad;
    load_word(16'hA5C3);
    checks++;
    if (ready !== 1'b0) begin
      failures++;
      $display("FAIL load_ready: got %b expected 0", ready);
    end
    pulse_start();
    checks++;
    if ({signal, bit_strobe, busy} !== 3'b111) begin
      failures++;
      $display("FAIL first_bit: got %b expected 111 (signal,strobe,busy)",
               {signal, bit_strobe, busy});
    end
    capture(400, -1, 2'd0, -1);
    checks++;
    if (!got_done || total_cyc != 200) begin
      failures++;
      $display("FAIL word_total: got done=%0d cycles=%0d expected done=1 cycles=200",
               got_done, total_cyc);
    end
    bad = 0;
    if (bits_q.size() != 20 || lens_q.size() != 20) bad = 99;
    else for (int i = 0; i < 20; i++)
      if (bits_q[i] != exp_frame_bit(16'hA5C3, i) || lens_q[i] != 10) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL word_bits: got %0d bits with %0d errors expected 20 bits of 1010+A5C3 at 10 clocks",
               bits_q.size(), bad);
    end
    checks++;
    if ({signal, busy, ready} !== 3'b001) begin
      failures++;
      $display("FAIL word_end: got %b expected 001 (signal,busy,ready)", {signal, busy, ready});
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse: got %b expected 0 one cycle later", done);
    end
  endtask

  task automatic test_phase_adj(input logic [1:0] adj, input int exp_len);
    int bad;
    load_word(16'h5A3C);
    pulse_start();
    capture(400, 2, adj, -1);
    checks++;
    if (!got_done || total_cyc != 190 + exp_len) begin
      failures++;
      $display("FAIL phase_total adj=%0d: got done=%0d cycles=%0d expected %0d",
               adj, got_done, total_cyc, 190 + exp_len);
    end
    bad = 0;
    if (lens_q.size() != 20) bad = 99;
    else for (int i = 0; i < 20; i++)
      if (lens_q[i] != ((i == 2) ? exp_len : 10)) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL phase_lens adj=%0d: got %0d length errors (bit2=%0d) expected bit2=%0d others 10",
               adj, bad, (lens_q.size() > 2) ? lens_q[2] : -1, exp_len);
    end
    bad = 0;
    if (bits_q.size() != 20) bad = 99;
    else for (int i = 0; i < 20; i++)
      if (bits_q[i] != exp_frame_bit(16'h5A3C, i)) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL phase_bits adj=%0d: got %0d bit errors expected 0", adj, bad);
    end
  endtask

  task automatic test_prbs();
    logic [6:0] s;
    int bad;
    apply_reset();
    mode  = 1'b1;
    start = 1'b1;
    @(negedge clk);
    capture(3000, -1, 2'd0, 149);
    mode = 1'b0;
    checks++;
    if (!got_done || bits_q.size() != 164 || total_cyc != 1640) begin
      failures++;
      $display("FAIL prbs_len: got done=%0d bits=%0d cycles=%0d expected 1 164 1640",
               got_done, bits_q.size(), total_cyc);
    end
    if (bits_q.size() == 164) begin
      bad = 0;
      for (int i = 4; i < 11; i++) if (bits_q[i] != 1'b1) bad++;
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL prbs_seed: got %0d zeros in first 7 data bits expected 0", bad);
      end
      bad = 0;
      s = 7'h7F;
      for (int i = 0; i < 160; i++) begin
        if (bits_q[4 + i] != s[6]) bad++;
        s = {s[5:0], s[6] ^ s[5]};
      end
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL prbs_seq: got %0d bit errors expected 0", bad);
      end
      bad = 0;
      for (int i = 0; i < 33; i++) if (bits_q[4 + i] != bits_q[131 + i]) bad++;
      foreach (lens_q[i]) if (lens_q[i] != 10) bad++;
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL prbs_period: got %0d period/gap errors expected 0", bad);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int bad;
    load_word(16'h1234);
    pulse_start();
    wait_strobes(10, 200, ok);
    checks++;
    if (!ok || ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ready_rise: got ok=%0d ready=%b expected 1 1", ok, ready);
    end
    load_word(16'hBEEF);
    checks++;
    if (ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_load: got ready=%b expected 0", ready);
    end
    load_word(16'hFFFF);
    checks++;
    if (ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second_load: got ready=%b expected 0", ready);
    end
    capture(600, -1, 2'd0, -1);
    bad = 0;
    if (!got_done || bits_q.size() != 26 || lens_q.size() != 26) bad = 99;
    else for (int i = 0; i < 26; i++) begin
      if (lens_q[i] != 10) bad++;
      if (i < 10 && bits_q[i] != exp_frame_bit(16'h1234, i + 10)) bad++;
      if (i >= 10 && bits_q[i] != exp_frame_bit(16'hBEEF, i - 6)) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL b2b_stream: got %0d bits with %0d errors expected 26 bits 1234-tail+BEEF",
               bits_q.size(), bad);
    end
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_end_ready: got %b expected 1", ready);
    end
  endtask

  task automatic test_idle_ignore();
    mode  = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, bit_strobe, signal} !== 3'b000) begin
        failures++;
        $display("FAIL idle_ignore cycle %0d: got %b expected 000 (busy,strobe,signal)",
                 i, {busy, bit_strobe, signal});
      end
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_data();
    bit ok;
    int bad;
    load_word(16'hA5C3);
    pulse_start();
    wait_strobes(5, 200, ok);
    checks++;
    if (!ok || {signal, busy} !== 2'b11) begin
      failures++;
      $display("FAIL pre_reset: got ok=%0d %b expected 1 11 (signal,busy)", ok, {signal, busy});
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({signal, busy, ready, bit_strobe} !== 4'b0010) begin
      failures++;
      $display("FAIL async_reset: got %b expected 0010 (signal,busy,ready,strobe)",
               {signal, busy, ready, bit_strobe});
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    load_word(16'hA5C3);
    pulse_start();
    checks++;
    if ({signal, bit_strobe, busy} !== 3'b111) begin
      failures++;
      $display("FAIL restart_first_bit: got %b expected 111", {signal, bit_strobe, busy});
    end
    capture(400, -1, 2'd0, -1);
    bad = 0;
    if (!got_done || bits_q.size() != 20) bad = 99;
    else for (int i = 0; i < 20; i++) if (bits_q[i] != exp_frame_bit(16'hA5C3, i)) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL restart_frame: got %0d bits with %0d errors expected 20", bits_q.size(), bad);
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    mode      = 1'b0;
    data_in   = 16'd0;
    load      = 1'b0;
    phase_adj = 2'd0;
    @(negedge clk);
    test_reset();
    test_word();
    test_phase_adj(2'd1, 12);
    test_phase_adj(2'd2, 8);
    test_idle_ignore();
    test_back_to_back();
    test_prbs();
    test_reset_mid_data();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
